// File: rtl/fetch_decode.sv
// Multicycle fetch/decode stage: owns the PC, reads instruction memory over req/ack,
// holds the fetched word in IR and presents its fields to execute on valid/ready.
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'd1000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instruction,
  output logic [5:0]  opcode,
  output logic [5:0]  functionCode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm,
  output logic [31:0] pc_out,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_count
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] redirect_pc;
  logic        redirect_pending;

  // mem_req is registered and stays low for the first FETCH cycle after reset,
  // so an ack that was in flight when reset hit can never be mistaken for data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= FETCH;
      pc               <= RESET_PC;
      ir               <= '0;
      pc_out           <= '0;
      out_valid        <= 1'b0;
      mem_req          <= 1'b0;
      instr_count      <= '0;
      redirect_pending <= 1'b0;
      redirect_pc      <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
            if (branch_taken) pc <= branch_target;
          end else if (mem_ack) begin
            // A redirect seen during this request makes the returned word stale.
            if (branch_taken) begin
              pc               <= branch_target;
              redirect_pending <= 1'b0;
            end else if (redirect_pending) begin
              pc               <= redirect_pc;
              redirect_pending <= 1'b0;
            end else begin
              ir        <= mem_rdata;
              pc_out    <= pc;
              pc        <= pc + PC_STEP;
              state     <= HOLD;
              out_valid <= 1'b1;
              mem_req   <= 1'b0;
            end
          end else if (branch_taken) begin
            redirect_pending <= 1'b1;
            redirect_pc      <= branch_target;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            pc        <= branch_target;
            state     <= FETCH;
            out_valid <= 1'b0;
            mem_req   <= 1'b1;
          end else if (out_ready) begin
            instr_count <= instr_count + 32'd1;
            state       <= FETCH;
            out_valid   <= 1'b0;
            mem_req     <= 1'b1;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign mem_addr     = pc;
  assign instruction  = ir;
  assign opcode       = ir[31:26];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign shamt        = ir[10:6];
  assign functionCode = ir[5:0];
  assign imm          = ir[15:0];

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: directed memory/branch stimulus, handoffs
// checked by a negedge monitor, plus a second instance for PC wrap and reset abort.
module tb_fetch_decode;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        reset, reset2;
  logic        mem_ack, mem_ack2;
  logic [31:0] mem_rdata;
  logic        out_ready;
  logic        branch_taken, branch_taken2;
  logic [31:0] branch_target;

  logic        mem_req, out_valid;
  logic [31:0] mem_addr, instruction, pc_out, instr_count;
  logic [5:0]  opcode, functionCode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  logic        mem_req2, out_valid2;
  logic [31:0] mem_addr2, instruction2, pc_out2, instr_count2;
  logic [5:0]  opcode2, functionCode2;
  logic [4:0]  rs2, rt2, rd2, shamt2;
  logic [15:0] imm2;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  fetch_decode dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .instruction(instruction), .opcode(opcode),
    .functionCode(functionCode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm(imm), .pc_out(pc_out), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr_count(instr_count)
  );

  fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset2), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(mem_ack2), .mem_rdata(mem_rdata), .out_valid(out_valid2),
    .out_ready(out_ready), .instruction(instruction2), .opcode(opcode2),
    .functionCode(functionCode2), .rs(rs2), .rt(rt2), .rd(rd2), .shamt(shamt2),
    .imm(imm2), .pc_out(pc_out2), .branch_taken(branch_taken2),
    .branch_target(branch_target), .instr_count(instr_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
  endtask

  // Advance one rising edge, then drive/check 2ns later, clear of the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #2;
  endtask

  task automatic pushExpected(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted, non-squashed handoff must match the next queued instruction.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !branch_taken) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL sb_unexpected: got handoff of %h expected none", instruction);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("sb_instruction", instruction, e.instr);
        checkOutput("sb_opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
        checkOutput("sb_rs", {27'd0, rs}, {27'd0, e.instr[25:21]});
        checkOutput("sb_rt", {27'd0, rt}, {27'd0, e.instr[20:16]});
        checkOutput("sb_rd", {27'd0, rd}, {27'd0, e.instr[15:11]});
        checkOutput("sb_shamt", {27'd0, shamt}, {27'd0, e.instr[10:6]});
        checkOutput("sb_funct", {26'd0, functionCode}, {26'd0, e.instr[5:0]});
        checkOutput("sb_imm", {16'd0, imm}, {16'd0, e.instr[15:0]});
        checkOutput("sb_pc_out", pc_out, e.pc);
      end
    end
  end

  task automatic doReset();
    reset = 1'b1; mem_ack = 1'b0; branch_taken = 1'b0; out_ready = 1'b0;
    applyStimulus();
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_instruction", instruction, 32'd0);
    checkOutput("rst_pc_out", pc_out, 32'd0);
    checkOutput("rst_count", instr_count, 32'd0);
    reset = 1'b0;
    applyStimulus();
    checkOutput("first_req", {31'd0, mem_req}, 32'd1);
    checkOutput("first_addr", mem_addr, 32'd1000);
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1; mem_ack = 1'b0; mem_ack2 = 1'b0;
    mem_rdata = '0; out_ready = 1'b0; branch_taken = 1'b0; branch_taken2 = 1'b0;
    branch_target = '0;

    // Zero-wait R-type fetch
    doReset();
    mem_ack = 1'b1; mem_rdata = 32'h014B_4820; out_ready = 1'b1;
    pushExpected(32'h014B_4820, 32'd1000);
    applyStimulus();
    mem_ack = 1'b0;
    checkOutput("t1_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t1_req_low", {31'd0, mem_req}, 32'd0);
    checkOutput("t1_opcode", {26'd0, opcode}, 32'd0);
    checkOutput("t1_rs", {27'd0, rs}, 32'd10);
    checkOutput("t1_rt", {27'd0, rt}, 32'd11);
    checkOutput("t1_rd", {27'd0, rd}, 32'd9);
    checkOutput("t1_funct", {26'd0, functionCode}, 32'h20);
    checkOutput("t1_pc_out", pc_out, 32'd1000);
    applyStimulus();
    checkOutput("t1_next_addr", mem_addr, 32'd1004);
    checkOutput("t1_count", instr_count, 32'd1);

    // lw with ack delayed 3 cycles
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("t2_wait_addr", mem_addr, 32'd1000);
      checkOutput("t2_wait_req", {31'd0, mem_req}, 32'd1);
    end
    mem_ack = 1'b1; mem_rdata = 32'h8C08_0010; out_ready = 1'b1;
    pushExpected(32'h8C08_0010, 32'd1000);
    applyStimulus();
    mem_ack = 1'b0;
    checkOutput("t2_opcode", {26'd0, opcode}, 32'h23);
    checkOutput("t2_imm", {16'd0, imm}, 32'h0010);
    applyStimulus();
    checkOutput("t2_count", instr_count, 32'd1);

    // Backpressure in HOLD
    out_ready = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0085_1020;
    pushExpected(32'h0085_1020, 32'd1004);
    applyStimulus();
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("t3_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("t3_instr", instruction, 32'h0085_1020);
      checkOutput("t3_req", {31'd0, mem_req}, 32'd0);
      checkOutput("t3_count", instr_count, 32'd1);
    end
    out_ready = 1'b1;
    applyStimulus();
    checkOutput("t3_count_inc", instr_count, 32'd2);
    checkOutput("t3_resume_addr", mem_addr, 32'd1008);

    // Branch while holding: squash
    mem_ack = 1'b1; mem_rdata = 32'h1000_FFFF;
    applyStimulus();
    mem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'd1032;
    applyStimulus();
    branch_taken = 1'b0;
    checkOutput("t4_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t4_count", instr_count, 32'd2);
    checkOutput("t4_addr", mem_addr, 32'd1032);

    // Branch during a pending fetch, ack two cycles later
    branch_taken = 1'b1; branch_target = 32'd2000;
    applyStimulus();
    branch_taken = 1'b0;
    checkOutput("t5_hold_addr", mem_addr, 32'd1032);
    applyStimulus();
    checkOutput("t5_hold_addr2", mem_addr, 32'd1032);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    applyStimulus();
    mem_ack = 1'b0;
    checkOutput("t5_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t5_ir_kept", instruction, 32'h1000_FFFF);
    checkOutput("t5_addr", mem_addr, 32'd2000);
    mem_ack = 1'b1; mem_rdata = 32'h2008_000A;
    pushExpected(32'h2008_000A, 32'd2000);
    applyStimulus();
    mem_ack = 1'b0;
    applyStimulus();
    checkOutput("t5_count", instr_count, 32'd3);

    // Same-cycle target beats a pending one
    branch_taken = 1'b1; branch_target = 32'd4000;
    applyStimulus();
    mem_ack = 1'b1; branch_target = 32'd5000;
    applyStimulus();
    mem_ack = 1'b0; branch_taken = 1'b0;
    checkOutput("t6_addr", mem_addr, 32'd5000);
    checkOutput("t6_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t6_count", instr_count, 32'd3);

    // Second instance: PC wrap and reset abandoning a request
    reset2 = 1'b1; mem_ack2 = 1'b0; out_ready = 1'b1;
    applyStimulus();
    reset2 = 1'b0;
    applyStimulus();
    checkOutput("w_first_addr", mem_addr2, 32'hFFFF_FFFC);
    mem_ack2 = 1'b1; mem_rdata = 32'h0000_0020;
    applyStimulus();
    mem_ack2 = 1'b0;
    checkOutput("w_pc_out", pc_out2, 32'hFFFF_FFFC);
    applyStimulus();
    checkOutput("w_wrap_addr", mem_addr2, 32'd0);
    checkOutput("w_req", {31'd0, mem_req2}, 32'd1);
    reset2 = 1'b1; mem_ack2 = 1'b1; mem_rdata = 32'h1234_5678;
    applyStimulus();
    checkOutput("w_rst_req", {31'd0, mem_req2}, 32'd0);
    checkOutput("w_rst_addr", mem_addr2, 32'hFFFF_FFFC);
    checkOutput("w_rst_count", instr_count2, 32'd0);
    reset2 = 1'b0;
    applyStimulus();
    mem_ack2 = 1'b0;
    checkOutput("w_ack_ignored_valid", {31'd0, out_valid2}, 32'd0);
    checkOutput("w_ack_ignored_ir", instruction2, 32'd0);
    checkOutput("w_rereq", {31'd0, mem_req2}, 32'd1);

    applyStimulus();
    checkOutput("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
